// File: rtl/misc_pipe.sv
// Constant-arithmetic unit for the misc slot: x10 (wrap/saturate), /10 and %10 with a writeback tag.
// Latency STAGES cycles from acceptance to out_valid; one op per cycle when not stalled.
// A held output (out_valid && !out_ready) freezes every stage and drops in_ready; flush overrides.
module misc_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             busy
);

  // Select values 1 and 4..7 all decode to div10 (legacy non-zero rule).
  typedef enum logic [2:0] {
    OP_MUL10  = 3'd0,
    OP_DIV10  = 3'd1,
    OP_REM10  = 3'd2,
    OP_MULSAT = 3'd3
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             ovf;
  } res_t;

  // floor(a/10) = (a * ceil(2^(W+4)/10)) >> (W+4). The rounding error of the
  // reciprocal is at most 8 < 2^4, which keeps the quotient exact for every W-bit a.
  localparam int              SH      = WIDTH + 4;
  localparam int              PW      = 2 * WIDTH + 1;
  localparam logic [SH:0]     POW2    = {1'b1, {SH{1'b0}}};
  localparam logic [SH:0]     RECIP_W = (POW2 + (SH + 1)'(9)) / (SH + 1)'(10);
  localparam logic [WIDTH:0]  RECIP   = RECIP_W[WIDTH:0];

  logic                 stall;
  logic                 in_fire;
  logic [WIDTH+3:0]     mul_full;
  logic                 mul_ovf;
  logic [PW-1:0]        recip_prod;
  logic [WIDTH-1:0]     quot;
  logic [WIDTH-1:0]     quot_x10;
  logic [WIDTH-1:0]     rem;
  res_t                 in_res;

  logic [STAGES-1:0]    stg_vld;
  res_t                 stg_res [STAGES];

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall && !flush && rstn;
  assign in_fire  = in_valid && in_ready;

  // Compute all candidate results from the operand, then select by op.
  always_comb begin
    mul_full   = ({4'b0, in_a} << 3) + ({4'b0, in_a} << 1);
    mul_ovf    = |mul_full[WIDTH+3:WIDTH];
    recip_prod = PW'(in_a) * PW'(RECIP);
    quot       = WIDTH'(recip_prod >> SH);
    quot_x10   = (quot << 3) + (quot << 1);
    rem        = in_a - quot_x10;
    in_res     = '0;
    in_res.tag = in_tag;
    case (in_op)
      OP_MUL10: begin
        in_res.data = mul_full[WIDTH-1:0];
        in_res.ovf  = mul_ovf;
      end
      OP_REM10: begin
        in_res.data = rem;
      end
      OP_MULSAT: begin
        in_res.data = mul_ovf ? {WIDTH{1'b1}} : mul_full[WIDTH-1:0];
        in_res.ovf  = mul_ovf;
      end
      default: begin
        in_res.data = quot;
      end
    endcase
  end

  // Stage shift register: flush clears valids, stall freezes everything,
  // payload only moves with a valid op so outputs stay 0 after reset until the first result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_vld <= '0;
      for (int i = 0; i < STAGES; i++) stg_res[i] <= '0;
    end else if (flush) begin
      stg_vld <= '0;
    end else if (!stall) begin
      stg_vld[0] <= in_fire;
      if (in_fire) stg_res[0] <= in_res;
      for (int i = 1; i < STAGES; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        if (stg_vld[i-1]) stg_res[i] <= stg_res[i-1];
      end
    end
  end

  assign out_valid = stg_vld[STAGES-1];
  assign out_data  = stg_res[STAGES-1].data;
  assign out_tag   = stg_res[STAGES-1].tag;
  assign out_ovf   = stg_res[STAGES-1].ovf;
  assign busy      = |stg_vld;

endmodule

// File: tb/tb_misc_pipe.sv
// Bench for misc_pipe: a 32-bit/2-stage and a 16-bit/1-stage build side by side.
// Directed vector table, stall/flush/reset sequences, then random traffic vs a queue model.
// Inputs are shared; bsel picks which build gets in_valid and whose outputs are observed.
module tb_misc_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] ia;
  logic [2:0]  iop;
  logic [4:0]  itag;
  logic        fl;
  logic        ordy;
  logic        va;
  logic        vb;
  logic        bsel;

  logic        a_rdy, a_vld, a_ovf, a_busy;
  logic [31:0] a_dat;
  logic [4:0]  a_tag;
  logic        b_rdy, b_vld, b_ovf, b_busy;
  logic [15:0] b_dat;
  logic [4:0]  b_tag;

  logic        o_rdy, o_vld, o_ovf, o_busy;
  logic [63:0] o_dat;
  logic [4:0]  o_tag;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  misc_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_a (
    .clk(clk), .rstn(rstn), .in_valid(va), .in_ready(a_rdy), .in_a(ia), .in_op(iop),
    .in_tag(itag), .flush(fl), .out_valid(a_vld), .out_ready(ordy), .out_data(a_dat),
    .out_tag(a_tag), .out_ovf(a_ovf), .busy(a_busy)
  );

  misc_pipe #(.WIDTH(16), .STAGES(1), .TAG_W(5)) u_b (
    .clk(clk), .rstn(rstn), .in_valid(vb), .in_ready(b_rdy), .in_a(ia[15:0]), .in_op(iop),
    .in_tag(itag), .flush(fl), .out_valid(b_vld), .out_ready(ordy), .out_data(b_dat),
    .out_tag(b_tag), .out_ovf(b_ovf), .busy(b_busy)
  );

  assign o_rdy  = bsel ? b_rdy  : a_rdy;
  assign o_vld  = bsel ? b_vld  : a_vld;
  assign o_ovf  = bsel ? b_ovf  : a_ovf;
  assign o_busy = bsel ? b_busy : a_busy;
  assign o_dat  = bsel ? {48'b0, b_dat} : {32'b0, a_dat};
  assign o_tag  = bsel ? b_tag  : a_tag;

  typedef struct {
    logic        bs;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] exp;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        ovf;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [4:0] tag);
    va   = v && !bsel;
    vb   = v && bsel;
    iop  = op;
    ia   = a;
    itag = tag;
  endtask

  // Reference behaviour straight from the arithmetic definition of each op.
  function automatic exp_t model(input int w, input logic [2:0] op, input longint unsigned a,
                                 input logic [4:0] tag);
    exp_t r;
    longint unsigned lim;
    longint unsigned p;
    lim   = 64'd1 << w;
    p     = a * 10;
    r.tag = tag;
    r.ovf = 1'b0;
    case (op)
      3'd0: begin r.data = p % lim; r.ovf = (p >= lim); end
      3'd2: r.data = a % 10;
      3'd3: begin r.data = (p >= lim) ? lim - 1 : p; r.ovf = (p >= lim); end
      default: r.data = a / 10;
    endcase
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    logic [4:0] tg;
    tg   = 5'(idx + 3);
    bsel = v.bs;
    ordy = 1'b1;
    drive(1'b1, v.op, v.a, tg);
    tick();
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    lat = 1;
    while (!o_vld && lat < 8) begin
      tick();
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), 64'(lat), v.bs ? 64'd1 : 64'd2);
    chk($sformatf("vec%0d_data", idx), o_dat, {32'b0, v.exp});
    chk($sformatf("vec%0d_tag", idx), {59'b0, o_tag}, {59'b0, tg});
    chk($sformatf("vec%0d_ovf", idx), {63'b0, o_ovf}, {63'b0, v.ovf});
    tick();
  endtask

  // Random traffic with random backpressure; model results queued in acceptance order.
  task automatic run_random(input logic bs, input int ncyc);
    int w;
    logic held;
    logic [63:0] hdat;
    logic [4:0] htag;
    logic v;
    logic [31:0] a;
    longint unsigned lim;
    exp_t e;
    bsel = bs;
    w    = bs ? 16 : 32;
    lim  = 64'd1 << w;
    held = 1'b0;
    hdat = '0;
    htag = '0;
    for (int c = 0; c < ncyc + 12; c++) begin
      if (c < ncyc) begin
        v = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 3))
          0: a = 32'($urandom() % lim);
          1: a = 32'(lim / 10 + $urandom_range(0, 4) - 2);
          2: a = 32'($urandom_range(0, 30));
          default: a = 32'(lim - 1 - $urandom_range(0, 20));
        endcase
        drive(v, 3'($urandom_range(0, 7)), a, 5'($urandom_range(0, 31)));
        ordy = ($urandom_range(0, 3) != 0);
      end else begin
        drive(1'b0, 3'd0, 32'd0, 5'd0);
        ordy = 1'b1;
      end
      #1;
      if (held) begin
        chk("rand_hold_vld", {63'b0, o_vld}, 64'd1);
        chk("rand_hold_dat", o_dat, hdat);
        chk("rand_hold_tag", {59'b0, o_tag}, {59'b0, htag});
      end
      chk("rand_in_ready", {63'b0, o_rdy}, {63'b0, !(o_vld && !ordy)});
      if (o_vld && ordy) begin
        if (sb.size() == 0) begin
          chk("rand_spurious_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rand_data", o_dat, e.data);
          chk("rand_tag", {59'b0, o_tag}, {59'b0, e.tag});
          chk("rand_ovf", {63'b0, o_ovf}, {63'b0, e.ovf});
        end
      end
      if ((va || vb) && o_rdy) sb.push_back(model(w, iop, 64'(bs ? {16'b0, ia[15:0]} : ia), itag));
      held = o_vld && !ordy;
      hdat = o_dat;
      htag = o_tag;
      tick();
    end
    chk("rand_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    int nxt;
    int rcv;
    logic held;
    logic [63:0] hdat;
    logic seen;

    rstn = 1'b0; ia = '0; iop = '0; itag = '0; fl = 1'b0; ordy = 1'b1;
    va = 1'b0; vb = 1'b0; bsel = 1'b0;

    // Reset values of both builds.
    #3;
    chk("rst_a_vld", {63'b0, a_vld}, 64'd0);
    chk("rst_a_dat", {32'b0, a_dat}, 64'd0);
    chk("rst_a_tag_ovf", {58'b0, a_tag, a_ovf}, 64'd0);
    chk("rst_a_busy", {63'b0, a_busy}, 64'd0);
    chk("rst_a_rdy", {63'b0, a_rdy}, 64'd0);
    chk("rst_b_vld_dat", {47'b0, b_vld, b_dat}, 64'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk("rst_a_rdy_after", {63'b0, a_rdy}, 64'd1);
    chk("rst_b_rdy_after", {63'b0, b_rdy}, 64'd1);

    // Directed vectors: {build, op, a, expected data, expected ovf}.
    tbl.push_back('{1'b0, 3'd0, 32'd7,          32'd70,         1'b0});
    tbl.push_back('{1'b0, 3'd1, 32'hFFFFFFFF,   32'h19999999,   1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'hFFFFFFFF,   32'd5,          1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'd0,          32'd0,          1'b0});
    tbl.push_back('{1'b0, 3'd1, 32'd9,          32'd0,          1'b0});
    tbl.push_back('{1'b0, 3'd1, 32'd10,         32'd1,          1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'h1999999A,   32'h00000004,   1'b1});
    tbl.push_back('{1'b0, 3'd3, 32'h1999999A,   32'hFFFFFFFF,   1'b1});
    tbl.push_back('{1'b0, 3'd3, 32'h19999999,   32'hFFFFFFFA,   1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'h19999999,   32'hFFFFFFFA,   1'b0});
    tbl.push_back('{1'b0, 3'd5, 32'd100,        32'd10,         1'b0});
    tbl.push_back('{1'b0, 3'd7, 32'd12345,      32'd1234,       1'b0});
    tbl.push_back('{1'b0, 3'd4, 32'd99,         32'd9,          1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'd12345,      32'd5,          1'b0});
    tbl.push_back('{1'b1, 3'd1, 32'h0000FFFF,   32'h00001999,   1'b0});
    tbl.push_back('{1'b1, 3'd2, 32'h0000FFFF,   32'd5,          1'b0});
    tbl.push_back('{1'b1, 3'd0, 32'h0000199A,   32'h00000004,   1'b1});
    tbl.push_back('{1'b1, 3'd3, 32'h0000199A,   32'h0000FFFF,   1'b1});
    tbl.push_back('{1'b1, 3'd3, 32'h00001999,   32'h0000FFFA,   1'b0});
    tbl.push_back('{1'b1, 3'd6, 32'h0000FFFA,   32'h00001999,   1'b0});
    tbl.push_back('{1'b1, 3'd2, 32'h00001234,   32'd0,          1'b0});
    foreach (tbl[i]) run_vec(tbl[i], i);

    // Stream 1..8 x10 with out_ready low for three cycles mid-stream.
    bsel = 1'b0;
    nxt  = 0;
    rcv  = 0;
    held = 1'b0;
    hdat = '0;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      ordy = !(c >= 4 && c <= 6);
      drive(nxt < 8, 3'd0, 32'(nxt + 1), 5'(nxt));
      #1;
      if (held) chk("stream_hold_dat", o_dat, hdat);
      if (o_vld && !ordy) chk("stream_stall_rdy", {63'b0, o_rdy}, 64'd0);
      if (o_vld && ordy) begin
        chk("stream_dat", o_dat, 64'(10 * (rcv + 1)));
        rcv++;
      end
      held = o_vld && !ordy;
      hdat = o_dat;
      if (va && o_rdy) nxt++;
      tick();
    end
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    ordy = 1'b1;
    chk("stream_count", 64'(rcv), 64'd8);
    tick();
    chk("stream_idle", {63'b0, o_busy}, 64'd0);

    // Flush with one op in the pipe and a second presented alongside the flush.
    drive(1'b1, 3'd0, 32'd5, 5'd1);
    tick();
    drive(1'b1, 3'd0, 32'd6, 5'd2);
    fl = 1'b1;
    #1;
    chk("flush_in_ready", {63'b0, o_rdy}, 64'd0);
    tick();
    fl = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    chk("flush_busy", {63'b0, o_busy}, 64'd0);
    seen = o_vld;
    for (int c = 0; c < 4; c++) begin tick(); seen = seen | o_vld; end
    chk("flush_no_out", {63'b0, seen}, 64'd0);

    // Flush overriding a stalled output with a second op behind it.
    ordy = 1'b0;
    drive(1'b1, 3'd0, 32'd11, 5'd3);
    tick();
    drive(1'b1, 3'd0, 32'd12, 5'd4);
    tick();
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    chk("stallflush_held_vld", {63'b0, o_vld}, 64'd1);
    chk("stallflush_held_dat", o_dat, 64'd110);
    fl = 1'b1;
    tick();
    fl = 1'b0;
    ordy = 1'b1;
    chk("stallflush_vld", {63'b0, o_vld}, 64'd0);
    chk("stallflush_busy", {63'b0, o_busy}, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin tick(); seen = seen | o_vld; end
    chk("stallflush_no_out", {63'b0, seen}, 64'd0);

    // Asynchronous reset mid-flight.
    drive(1'b1, 3'd0, 32'd21, 5'd7);
    tick();
    drive(1'b1, 3'd0, 32'd22, 5'd8);
    #2;
    rstn = 1'b0;
    #1;
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    chk("arst_vld", {63'b0, o_vld}, 64'd0);
    chk("arst_dat", o_dat, 64'd0);
    chk("arst_tag_ovf", {58'b0, o_tag, o_ovf}, 64'd0);
    chk("arst_busy", {63'b0, o_busy}, 64'd0);
    chk("arst_in_ready", {63'b0, o_rdy}, 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk("arst_rdy_after", {63'b0, o_rdy}, 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin tick(); seen = seen | o_vld; end
    chk("arst_no_out", {63'b0, seen}, 64'd0);

    // Random sweeps on both builds.
    run_random(1'b0, 3000);
    run_random(1'b1, 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
